// File: rtl/pfs_pkg.sv
// pfs_pkg: shared FSM state, particle record and boundary limits for particle_frame_sequencer
package pfs_pkg;
    localparam int PW = 16;
    localparam logic signed [PW-1:0] XMAX = 16'sd1000;
    localparam logic signed [PW-1:0] YMAX = 16'sd1000;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, NEXT, DONE} state_t;
    typedef struct packed {
        logic signed [PW-1:0] x;
        logic signed [PW-1:0] y;
        logic signed [PW-1:0] vx;
        logic signed [PW-1:0] vy;
        logic signed [PW-1:0] ax;
        logic signed [PW-1:0] ay;
    } particle_t;
endpackage

// File: rtl/pfs_regfile.sv
// pfs_regfile: N_PART-entry particle store, one sync write port, combinational FSM read, registered host read
// Ports: clock/reset; we/widx/wdata write; fidx->fdata comb read; hidx->hx,hy,hvx,hvy registered read
module pfs_regfile import pfs_pkg::*; #(
    parameter int N_PART = 8,
    parameter int IDXW   = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 we,
    input  logic [IDXW-1:0]      widx,
    input  particle_t            wdata,
    input  logic [IDXW-1:0]      fidx,
    output particle_t            fdata,
    input  logic [IDXW-1:0]      hidx,
    output logic signed [PW-1:0] hx,
    output logic signed [PW-1:0] hy,
    output logic signed [PW-1:0] hvx,
    output logic signed [PW-1:0] hvy
);
    particle_t mem [N_PART];

    assign fdata = mem[fidx];

    // Indices beyond N_PART (non power-of-two sizes) write nothing and read as zero
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_PART; i++) mem[i] <= '0;
            hx  <= '0;
            hy  <= '0;
            hvx <= '0;
            hvy <= '0;
        end else begin
            if (we && int'(widx) < N_PART) mem[widx] <= wdata;
            hx  <= (int'(hidx) < N_PART) ? mem[hidx].x  : '0;
            hy  <= (int'(hidx) < N_PART) ? mem[hidx].y  : '0;
            hvx <= (int'(hidx) < N_PART) ? mem[hidx].vx : '0;
            hvy <= (int'(hidx) < N_PART) ? mem[hidx].vy : '0;
        end
    end
endmodule

// File: rtl/particle_frame_sequencer.sv
// particle_frame_sequencer: walks all stored particles through update_module once per frame and writes results back
// Ports: clock/reset; start/t_step frame launch; ld_* host load, rd_* host readback of ld_idx (1-cycle latency);
//        upd_* operands + upd_in_rdy to update_module, upd_*new + upd_out_rdy results back;
//        busy, frame_done, frame_cnt, timeout_err status.
// Optional macro BOUNDARY_REFLECT_EN: clamp x/y into [0,XMAX]/[0,YMAX] on write-back and negate the matching velocity.
// W must equal pfs_pkg::PW (the particle record width).
module particle_frame_sequencer import pfs_pkg::*; #(
    parameter int N_PART  = 8,
    parameter int W       = 16,
    parameter int IDXW    = 3,
    parameter int TIMEOUT = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [W-1:0]    t_step,
    input  logic            ld_en,
    input  logic [IDXW-1:0] ld_idx,
    input  logic [W-1:0]    ld_x,
    input  logic [W-1:0]    ld_y,
    input  logic [W-1:0]    ld_vx,
    input  logic [W-1:0]    ld_vy,
    input  logic [W-1:0]    ld_ax,
    input  logic [W-1:0]    ld_ay,
    output logic [W-1:0]    rd_x,
    output logic [W-1:0]    rd_y,
    output logic [W-1:0]    rd_vx,
    output logic [W-1:0]    rd_vy,
    output logic [W-1:0]    upd_x,
    output logic [W-1:0]    upd_y,
    output logic [W-1:0]    upd_vx,
    output logic [W-1:0]    upd_vy,
    output logic [W-1:0]    upd_ax,
    output logic [W-1:0]    upd_ay,
    output logic [W-1:0]    upd_t,
    output logic            upd_in_rdy,
    input  logic [W-1:0]    upd_xnew,
    input  logic [W-1:0]    upd_ynew,
    input  logic [W-1:0]    upd_vxnew,
    input  logic [W-1:0]    upd_vynew,
    input  logic            upd_out_rdy,
    output logic            busy,
    output logic            frame_done,
    output logic [15:0]     frame_cnt,
    output logic            timeout_err
);
    localparam int CW = $clog2(TIMEOUT);

    state_t               state;
    logic [IDXW-1:0]      idx;
    logic [W-1:0]         t_lat;
    logic [CW-1:0]        cnt;
    logic signed [W-1:0]  res_x, res_y, res_vx, res_vy;
    particle_t            cur, wb, ld_p, wdata;
    logic                 we;
    logic [IDXW-1:0]      widx;

    // Host loads only land while idle; a load coinciding with start is written before ISSUE reads it
    always_comb begin
        ld_p  = '{x: ld_x, y: ld_y, vx: ld_vx, vy: ld_vy, ax: ld_ax, ay: ld_ay};
        we    = (state == WRITE) || (state == IDLE && ld_en);
        widx  = (state == WRITE) ? idx : ld_idx;
        wdata = (state == WRITE) ? wb : ld_p;
    end

    pfs_regfile #(.N_PART(N_PART), .IDXW(IDXW)) u_rf (
        .clock (clock),
        .reset (reset),
        .we    (we),
        .widx  (widx),
        .wdata (wdata),
        .fidx  (idx),
        .fdata (cur),
        .hidx  (ld_idx),
        .hx    (rd_x),
        .hy    (rd_y),
        .hvx   (rd_vx),
        .hvy   (rd_vy)
    );

`ifdef BOUNDARY_REFLECT_EN
    logic x_lo, x_hi, y_lo, y_hi;
    always_comb begin
        x_lo  = res_x[W-1];
        x_hi  = res_x > XMAX;
        y_lo  = res_y[W-1];
        y_hi  = res_y > YMAX;
        wb    = cur;
        wb.x  = x_lo ? '0 : (x_hi ? XMAX : res_x);
        wb.vx = (x_lo || x_hi) ? -res_vx : res_vx;
        wb.y  = y_lo ? '0 : (y_hi ? YMAX : res_y);
        wb.vy = (y_lo || y_hi) ? -res_vy : res_vy;
    end
`else
    // Acceleration is carried over from the stored entry; only x,y,vx,vy come back from update_module
    always_comb begin
        wb    = cur;
        wb.x  = res_x;
        wb.y  = res_y;
        wb.vx = res_vx;
        wb.vy = res_vy;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            t_lat       <= '0;
            cnt         <= '0;
            res_x       <= '0;
            res_y       <= '0;
            res_vx      <= '0;
            res_vy      <= '0;
            upd_x       <= '0;
            upd_y       <= '0;
            upd_vx      <= '0;
            upd_vy      <= '0;
            upd_ax      <= '0;
            upd_ay      <= '0;
            upd_t       <= '0;
            upd_in_rdy  <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    t_lat <= t_step;
                    idx   <= '0;
                    busy  <= 1'b1;
                    state <= ISSUE;
                end
                ISSUE: begin
                    upd_x      <= cur.x;
                    upd_y      <= cur.y;
                    upd_vx     <= cur.vx;
                    upd_vy     <= cur.vy;
                    upd_ax     <= cur.ax;
                    upd_ay     <= cur.ay;
                    upd_t      <= t_lat;
                    upd_in_rdy <= 1'b1;
                    cnt        <= '0;
                    state      <= WAIT;
                end
                // A timed-out particle skips WRITE so its stored state stays as it was
                WAIT: if (upd_out_rdy) begin
                    res_x  <= upd_xnew;
                    res_y  <= upd_ynew;
                    res_vx <= upd_vxnew;
                    res_vy <= upd_vynew;
                    state  <= WRITE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    timeout_err <= 1'b1;
                    state       <= NEXT;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                WRITE: begin
                    upd_in_rdy <= 1'b0;
                    state      <= NEXT;
                end
                NEXT: begin
                    upd_in_rdy <= 1'b0;
                    if (idx == IDXW'(N_PART - 1)) begin
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx   <= idx + IDXW'(1);
                        state <= ISSUE;
                    end
                end
                DONE: begin
                    frame_cnt <= frame_cnt + 16'd1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
